// File: rtl/trap_arbiter.sv
// trap_arbiter: picks exception / external IRQ / timer traps and walks the pipeline through drain, entry, handler and return.
// Build option TRAP_VECTORED_EN adds o_vec_off for vectored interrupt entry.
module trap_arbiter #(
    parameter int NUM_IRQ        = 4,
    parameter int CAUSE_W        = 5,
    parameter int IRQ_CAUSE_BASE = 16,
    parameter int DRAIN_MAX      = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_irq_en,
    input  logic               i_gie,
    input  logic               i_timer_irq,
    input  logic               i_timer_en,
    input  logic               i_excep,
    input  logic [CAUSE_W-1:0] i_excep_code,
    input  logic               i_mret,
    input  logic               i_drain_done,
    output logic [1:0]         o_pc_src,
    output logic               o_stall,
    output logic               o_flush,
    output logic               o_trap_take,
    output logic               o_is_intr,
    output logic [CAUSE_W-1:0] o_cause,
    output logic [NUM_IRQ-1:0] o_irq_claim,
    output logic               o_in_handler,
    output logic               o_mret_pulse,
`ifdef TRAP_VECTORED_EN
    output logic [CAUSE_W+1:0] o_vec_off,
`endif
    output logic               o_drain_tmo
);

    localparam logic [1:0] PC_RESET = 2'd0;
    localparam logic [1:0] PC_TRAP  = 2'd1;
    localparam logic [1:0] PC_EPC   = 2'd2;
    localparam logic [1:0] PC_NEXT  = 2'd3;

    localparam logic [CAUSE_W-1:0] TIMER_CAUSE = CAUSE_W'(7);
    localparam logic [7:0]         DRAIN_LAST  = 8'(DRAIN_MAX - 1);

    typedef enum logic [2:0] {
        RST_S   = 3'd0,
        RUN     = 3'd1,
        DRAIN   = 3'd2,
        TRAP    = 3'd3,
        HANDLER = 3'd4,
        RETURN  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CAUSE_W-1:0] r_cause;
    logic               r_is_intr;
    logic [NUM_IRQ-1:0] r_claim;
    logic [7:0]         r_drain_cnt;

    logic [NUM_IRQ-1:0] w_irq_act;
    logic               w_irq_any;
    logic               w_tmr_act;
    logic               w_intr_pend;
    logic               w_found;
    logic [CAUSE_W-1:0] w_irq_sel_cause;
    logic [NUM_IRQ-1:0] w_irq_sel_claim;
    logic [CAUSE_W-1:0] w_req_cause;
    logic               w_req_is_intr;
    logic [NUM_IRQ-1:0] w_req_claim;
    logic               w_drain_last;
    logic               w_cap_req;
    logic               w_cap_exc;
    logic               w_clr_claim;

    assign w_irq_act   = i_irq & i_irq_en & {NUM_IRQ{i_gie}};
    assign w_irq_any   = |w_irq_act;
    assign w_tmr_act   = i_gie & i_timer_irq & i_timer_en;
    assign w_intr_pend = w_irq_any | w_tmr_act;
    assign w_drain_last = (r_drain_cnt == DRAIN_LAST);

    // Lowest-numbered enabled line wins among external interrupts.
    always_comb begin
        w_found         = 1'b0;
        w_irq_sel_cause = '0;
        w_irq_sel_claim = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            if (w_irq_act[k] && !w_found) begin
                w_found            = 1'b1;
                w_irq_sel_cause    = CAUSE_W'(IRQ_CAUSE_BASE + k);
                w_irq_sel_claim[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_req_cause   = '0;
        w_req_is_intr = 1'b0;
        w_req_claim   = '0;
        if (i_excep) begin
            w_req_cause = i_excep_code;
        end else if (w_irq_any) begin
            w_req_cause   = w_irq_sel_cause;
            w_req_is_intr = 1'b1;
            w_req_claim   = w_irq_sel_claim;
        end else if (w_tmr_act) begin
            w_req_cause   = TIMER_CAUSE;
            w_req_is_intr = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= RST_S;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_pc_src     = PC_NEXT;
        o_stall      = 1'b0;
        o_flush      = 1'b0;
        o_trap_take  = 1'b0;
        o_in_handler = 1'b0;
        o_mret_pulse = 1'b0;
        o_drain_tmo  = 1'b0;
        w_cap_req    = 1'b0;
        w_cap_exc    = 1'b0;
        w_clr_claim  = 1'b0;
        case (r_state)
            RST_S: begin
                o_pc_src    = PC_RESET;
                o_flush     = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                if (i_excep || w_intr_pend) begin
                    w_cap_req   = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                o_stall = 1'b1;
                if (i_drain_done) begin
                    w_state_nxt = TRAP;
                end else if (w_drain_last) begin
                    o_drain_tmo = 1'b1;
                    w_state_nxt = TRAP;
                end
            end
            TRAP: begin
                o_pc_src    = PC_TRAP;
                o_flush     = 1'b1;
                o_trap_take = 1'b1;
                w_state_nxt = HANDLER;
            end
            HANDLER: begin
                // A fault inside the handler outranks a simultaneous mret.
                o_in_handler = 1'b1;
                if (i_excep) begin
                    w_cap_exc   = 1'b1;
                    w_state_nxt = DRAIN;
                end else if (i_mret) begin
                    w_clr_claim = 1'b1;
                    w_state_nxt = RETURN;
                end
            end
            RETURN: begin
                o_pc_src     = PC_EPC;
                o_flush      = 1'b1;
                o_mret_pulse = 1'b1;
                w_state_nxt  = RUN;
            end
            default: begin
                w_state_nxt = RST_S;
            end
        endcase
    end

    // Cause/claim are captured once on entry and held until the next trap or return.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cause     <= '0;
            r_is_intr   <= 1'b0;
            r_claim     <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_cap_req) begin
                r_cause   <= w_req_cause;
                r_is_intr <= w_req_is_intr;
                r_claim   <= w_req_claim;
            end else if (w_cap_exc) begin
                r_cause   <= i_excep_code;
                r_is_intr <= 1'b0;
                r_claim   <= '0;
            end else if (w_clr_claim) begin
                r_claim <= '0;
            end
            if ((r_state == DRAIN) && (w_state_nxt == DRAIN)) begin
                r_drain_cnt <= r_drain_cnt + 8'd1;
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    assign o_cause     = r_cause;
    assign o_is_intr   = r_is_intr;
    assign o_irq_claim = r_claim;

`ifdef TRAP_VECTORED_EN
    assign o_vec_off = (o_trap_take && r_is_intr) ? {r_cause, 2'b00} : '0;
`endif

endmodule

// File: doc/trap_arbiter.md
TRAP_ARBITER -- requirements
Module: trap_arbiter

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of external interrupt lines (legal range 1..16).
REQ-002 SHALL have parameter CAUSE_W, default 5, width of the cause code.
REQ-003 SHALL have parameter IRQ_CAUSE_BASE, default 16, cause code of external line 0; line k uses IRQ_CAUSE_BASE+k, truncated to CAUSE_W.
REQ-004 SHALL have parameter DRAIN_MAX, default 8, the drain-wait timeout in cycles (legal range 1..255).
REQ-005 SHALL provide port i_clk  in  1  the single clock; all logic on rising edge.
REQ-006 SHALL provide port i_rst  in  1  synchronous, active-high reset.
REQ-007 SHALL provide port i_irq  in  NUM_IRQ  level-sensitive external interrupt lines.
REQ-008 SHALL provide port i_irq_en  in  NUM_IRQ  per-line enable mask.
REQ-009 SHALL provide port i_gie  in  1  global interrupt enable.
REQ-010 SHALL provide port i_timer_irq  in  1  timer interrupt level.
REQ-011 SHALL provide port i_timer_en  in  1  timer interrupt enable.
REQ-012 SHALL provide port i_excep  in  1  synchronous exception request (illegal or undecodable instruction).
REQ-013 SHALL provide port i_excep_code  in  CAUSE_W  exception cause code.
REQ-014 SHALL provide port i_mret  in  1  mret instruction retiring.
REQ-015 SHALL provide port i_drain_done  in  1  pipeline-empty acknowledge.
REQ-016 SHALL provide port o_pc_src  out  2  PC select: 0=RESET, 1=TRAP, 2=EPC, 3=NEXT.
REQ-017 SHALL provide the remaining outputs, each 1 bit unless stated:
- o_stall: holds fetch.
- o_flush: kills the IF/ID/EX stages.
- o_trap_take: trap entry pulse.
- o_is_intr: 1 = interrupt, 0 = exception.
- o_cause (CAUSE_W): latched cause code.
- o_irq_claim (NUM_IRQ): one-hot claimed line.
- o_in_handler: handler active.
- o_mret_pulse: return pulse.
- o_drain_tmo: drain timeout pulse.

Function
REQ-018 SHALL implement states RST_S, RUN, DRAIN, TRAP, HANDLER and RETURN.
REQ-019 RST_S SHALL drive o_pc_src=0 and o_flush=1, then always go to RUN.
REQ-020 An interrupt SHALL be pending when i_gie is 1 and either (|(i_irq & i_irq_en)) is 1 or (i_timer_irq & i_timer_en) is 1.
REQ-021 In RUN, if i_excep=1 or an interrupt is pending, the block SHALL latch cause, o_is_intr and o_irq_claim in the same cycle and go to DRAIN; otherwise it SHALL stay in RUN with o_pc_src=3.
REQ-022 Priority SHALL be: exception, then external lines (lowest index first), then timer (cause 7); simultaneous requests SHALL resolve in that order.
REQ-023 DRAIN SHALL assert o_stall=1 and go to TRAP on i_drain_done=1, or when a counter reaches DRAIN_MAX; on the timeout path o_drain_tmo SHALL pulse for 1 cycle.
REQ-024 Latched cause SHALL hold through DRAIN even if the source deasserts; a new request during DRAIN SHALL be ignored.
REQ-025 TRAP SHALL last exactly 1 cycle with o_pc_src=1, o_flush=1 and o_trap_take=1, then go to HANDLER.
REQ-026 Latency SHALL be: request sampled at cycle N, with i_drain_done=1 at N+1, gives o_trap_take at N+2.
REQ-027 HANDLER SHALL assert o_in_handler=1 and o_pc_src=3 and SHALL ignore all interrupts (no nesting).
REQ-028 In HANDLER, i_mret SHALL go to RETURN, and i_excep SHALL go to DRAIN with the cause overwritten.
REQ-029 In HANDLER, i_excep and i_mret asserted together SHALL take the exception.
REQ-030 RETURN SHALL last 1 cycle with o_pc_src=2, o_flush=1 and o_mret_pulse=1, clear o_in_handler and o_irq_claim, then go to RUN.
REQ-031 i_mret in RUN or DRAIN SHALL be ignored.
REQ-032 All outputs not specified for a state SHALL be 0, except o_pc_src=3.

Reset
REQ-033 i_rst=1 SHALL force RST_S at the next edge from any state, including mid-DRAIN and mid-HANDLER.
REQ-034 On reset, the drain counter, o_cause, o_irq_claim, o_is_intr, o_in_handler and all pulses SHALL be 0.

Configuration
REQ-035 With TRAP_VECTORED_EN defined, the block SHALL add output o_vec_off (CAUSE_W+2 bits), equal to o_cause<<2 when o_trap_take=1 and o_is_intr=1, and 0 otherwise.
REQ-036 Without TRAP_VECTORED_EN, the port SHALL be absent and all trap entries use the base vector.

Verification
REQ-037 i_irq=4'b0110, i_irq_en=4'b1111, i_gie=1, i_drain_done=1 -> o_trap_take at N+2, o_cause=17, o_irq_claim=4'b0010, o_is_intr=1.
REQ-038 i_excep=1, i_excep_code=2, i_timer_irq=1 in the same cycle -> o_cause=2, o_is_intr=0.
REQ-039 i_drain_done held 0 with DRAIN_MAX=8 -> o_drain_tmo and TRAP after 8 DRAIN cycles.
REQ-040 Interrupt in HANDLER, then i_mret -> no trap, o_mret_pulse=1, o_pc_src=2 for 1 cycle, and the still-pending interrupt traps again from RUN.
REQ-041 i_rst=1 during DRAIN -> next cycle o_pc_src=0, o_stall=0, o_cause=0.
REQ-042 With TRAP_VECTORED_EN, timer trap -> o_vec_off=28.
